// File: rtl/core_pipe_hcu.sv
//-----------------------------------------------------------------------------
// core_pipe_hcu
//
// Hazard-control and pipeline-sequencing unit for an in-order RV32I pipeline
// of NSTAGES stages (0=IF, 1=ID, 2=EX, NSTAGES-2=MEM, NSTAGES-1=WB).
//
// The unit keeps its own shadow copy of per-stage valid / rd / write-enable /
// memory-op flags. From that state and the ID-stage decode inputs it derives
// the PC and pipeline-register enables, bubble insertion, operand-forwarding
// selects and three saturating performance counters.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   IF_VALID, IMEM_BUSY       fetch side status
//   DMEM_BUSY                 MEM-stage data access still pending
//   ID_RS1/2, ID_RS1/2_USED   source operands of the ID instruction
//   ID_RD, ID_RD_WE           destination of the ID instruction
//   ID_IS_LOAD, ID_IS_MEM     ID instruction is a load / any memory op
//   EX_REDIRECT               EX instruction changes control flow
//   PC_WRITE                  PC register update enable
//   STAGE_EN[i]               register into stage i+1 loads
//   STAGE_BUBBLE[i]           register into stage i+1 loads a NOP
//   STAGE_VALID[i]            stage i+1 holds a valid instruction
//   FWD_A, FWD_B              0 = regfile, s = result of stage s
//   CNT_STALL/FLUSH/RETIRE    saturating performance counters
//-----------------------------------------------------------------------------
module core_pipe_hcu #(
  parameter int NSTAGES = 5,
  parameter int AW      = 5,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IF_VALID,
  input  logic                       IMEM_BUSY,
  input  logic                       DMEM_BUSY,
  input  logic [AW-1:0]              ID_RS1,
  input  logic [AW-1:0]              ID_RS2,
  input  logic                       ID_RS1_USED,
  input  logic                       ID_RS2_USED,
  input  logic [AW-1:0]              ID_RD,
  input  logic                       ID_RD_WE,
  input  logic                       ID_IS_LOAD,
  input  logic                       ID_IS_MEM,
  input  logic                       EX_REDIRECT,
  output logic                       PC_WRITE,
  output logic [NSTAGES-2:0]         STAGE_EN,
  output logic [NSTAGES-2:0]         STAGE_BUBBLE,
  output logic [NSTAGES-2:0]         STAGE_VALID,
  output logic [$clog2(NSTAGES)-1:0] FWD_A,
  output logic [$clog2(NSTAGES)-1:0] FWD_B,
  output logic [CNT_W-1:0]           CNT_STALL,
  output logic [CNT_W-1:0]           CNT_FLUSH,
  output logic [CNT_W-1:0]           CNT_RETIRE
);

  localparam int EX  = 2;
  localparam int MEM = NSTAGES - 2;
  localparam int WB  = NSTAGES - 1;
  localparam int NB  = NSTAGES - 1;
  localparam int FW  = $clog2(NSTAGES);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Shadow pipeline state. Only the flags that some hazard rule reads are
  // tracked: mem-op up to MEM, load only in EX (the load-use window).
  logic [WB:1]      valid_r;
  logic [WB:2]      we_r;
  logic [AW-1:0]    rd_r [WB:2];
  logic [MEM:2]     mem_r;
  logic             load_ex_r;

  logic [CNT_W-1:0] cnt_stall_r;
  logic [CNT_W-1:0] cnt_flush_r;
  logic [CNT_W-1:0] cnt_retire_r;

  logic [WB:2]      match_a_s;
  logic [WB:2]      match_b_s;
  logic             dstall_s;
  logic             redir_s;
  logic             raw_s;
  logic             fetch_s;
  logic             pc_write_s;
  logic             flush_s;
  logic [NB-1:0]    stage_en_s;
  logic [NB-1:0]    stage_bubble_s;
  logic [FW-1:0]    fwd_a_s;
  logic [FW-1:0]    fwd_b_s;

  // Per-stage RAW match of each ID source operand (x0 never matches).
  always_comb begin
    match_a_s = {(NSTAGES-2){1'b0}};
    match_b_s = {(NSTAGES-2){1'b0}};
    for (int s = 2; s <= WB; s++) begin
      match_a_s[s] = valid_r[1] & valid_r[s] & we_r[s] & ID_RS1_USED &
                     (ID_RS1 != {AW{1'b0}}) & (rd_r[s] == ID_RS1);
      match_b_s[s] = valid_r[1] & valid_r[s] & we_r[s] & ID_RS2_USED &
                     (ID_RS2 != {AW{1'b0}}) & (rd_r[s] == ID_RS2);
    end
  end

  // Raw hazard predicates, before priority resolution.
  assign dstall_s = DMEM_BUSY & valid_r[MEM] & mem_r[MEM];
  assign redir_s  = EX_REDIRECT & valid_r[EX];
  // With forwarding only a load still in EX cannot be bypassed in time.
  assign raw_s    = (FWD_EN != 32'sd0) ?
                    ((match_a_s[EX] | match_b_s[EX]) & load_ex_r) :
                    ((|match_a_s) | (|match_b_s));
  assign fetch_s  = IMEM_BUSY | ~IF_VALID;

  // Priority-resolved PC / stage enables and bubble insertion.
  always_comb begin
    pc_write_s     = 1'b1;
    stage_en_s     = {NB{1'b1}};
    stage_bubble_s = {NB{1'b0}};
    flush_s        = 1'b0;
    if (RST) begin
      pc_write_s     = 1'b0;
      stage_en_s     = {NB{1'b0}};
      stage_bubble_s = {NB{1'b1}};
    end else if (dstall_s) begin
      // IF..MEM freeze; WB drains into a bubble so the stalled op retires once.
      pc_write_s     = 1'b0;
      stage_en_s     = {1'b1, {(NB-1){1'b0}}};
      stage_bubble_s = {1'b1, {(NB-1){1'b0}}};
    end else if (redir_s) begin
      // Squash the wrong-path instructions in IF and ID.
      stage_bubble_s[0] = 1'b1;
      stage_bubble_s[1] = 1'b1;
      flush_s           = 1'b1;
    end else if (raw_s) begin
      pc_write_s        = 1'b0;
      stage_en_s[0]     = 1'b0;
      stage_bubble_s[1] = 1'b1;
    end else if (fetch_s) begin
      pc_write_s        = 1'b0;
      stage_bubble_s[0] = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  // Forwarding select: youngest producer (lowest stage index) wins.
  always_comb begin
    fwd_a_s = {FW{1'b0}};
    fwd_b_s = {FW{1'b0}};
    if (!RST && (FWD_EN != 32'sd0) && !raw_s) begin
      for (int s = WB; s >= 2; s--) begin
        fwd_a_s = match_a_s[s] ? FW'(s) : fwd_a_s;
        fwd_b_s = match_b_s[s] ? FW'(s) : fwd_b_s;
      end
    end else begin
      fwd_a_s = {FW{1'b0}};
      fwd_b_s = {FW{1'b0}};
    end
  end

  // Shadow pipeline flags follow the stage enables; bubbles clear them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r   <= {(NSTAGES-1){1'b0}};
      we_r      <= {(NSTAGES-2){1'b0}};
      mem_r     <= {(NSTAGES-3){1'b0}};
      load_ex_r <= 1'b0;
      for (int s = 2; s <= WB; s++) begin
        rd_r[s] <= {AW{1'b0}};
      end
    end else begin
      if (stage_en_s[0]) begin
        valid_r[1] <= IF_VALID & ~stage_bubble_s[0];
      end
      if (stage_en_s[1]) begin
        valid_r[EX] <= valid_r[1] & ~stage_bubble_s[1];
        we_r[EX]    <= ID_RD_WE & ~stage_bubble_s[1];
        mem_r[EX]   <= ID_IS_MEM & ~stage_bubble_s[1];
        load_ex_r   <= ID_IS_LOAD & ~stage_bubble_s[1];
        rd_r[EX]    <= stage_bubble_s[1] ? {AW{1'b0}} : ID_RD;
      end
      for (int s = 3; s <= WB; s++) begin
        if (stage_en_s[s-1]) begin
          valid_r[s] <= valid_r[s-1] & ~stage_bubble_s[s-1];
          we_r[s]    <= we_r[s-1] & ~stage_bubble_s[s-1];
          rd_r[s]    <= stage_bubble_s[s-1] ? {AW{1'b0}} : rd_r[s-1];
        end
      end
      for (int s = 3; s <= MEM; s++) begin
        if (stage_en_s[s-1]) begin
          mem_r[s] <= mem_r[s-1] & ~stage_bubble_s[s-1];
        end
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_stall_r  <= {CNT_W{1'b0}};
      cnt_flush_r  <= {CNT_W{1'b0}};
      cnt_retire_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s && (cnt_stall_r != CNT_MAX)) begin
        cnt_stall_r <= cnt_stall_r + CNT_ONE;
      end
      if (flush_s && (cnt_flush_r != CNT_MAX)) begin
        cnt_flush_r <= cnt_flush_r + CNT_ONE;
      end
      if (valid_r[WB] && (cnt_retire_r != CNT_MAX)) begin
        cnt_retire_r <= cnt_retire_r + CNT_ONE;
      end
    end
  end

  assign PC_WRITE     = pc_write_s;
  assign STAGE_EN     = stage_en_s;
  assign STAGE_BUBBLE = stage_bubble_s;
  assign STAGE_VALID  = valid_r;
  assign FWD_A        = fwd_a_s;
  assign FWD_B        = fwd_b_s;
  assign CNT_STALL    = cnt_stall_r;
  assign CNT_FLUSH    = cnt_flush_r;
  assign CNT_RETIRE   = cnt_retire_r;

endmodule

// File: tb/tb_core_pipe_hcu.sv
//-----------------------------------------------------------------------------
// tb_core_pipe_hcu
//
// Two instances share one stimulus: u_a (defaults, forwarding on) and u_b
// (no forwarding, 4-bit counters). A record-level pipeline model per instance
// predicts every output each cycle; directed steps add scenario-specific
// expectations on top of that.
//-----------------------------------------------------------------------------
module tb_core_pipe_hcu;

  logic       CLK = 1'b0;
  logic       RST, IF_VALID, IMEM_BUSY, DMEM_BUSY, EX_REDIRECT;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_RS1_USED, ID_RS2_USED, ID_RD_WE, ID_IS_LOAD, ID_IS_MEM;

  logic        a_pcw, b_pcw;
  logic [3:0]  a_en, a_bub, a_sv, b_en, b_bub, b_sv;
  logic [2:0]  a_fa, a_fb, b_fa, b_fb;
  logic [15:0] a_cs, a_cf, a_cr;
  logic [3:0]  b_cs, b_cf, b_cr;

  always #5 CLK = ~CLK;

  core_pipe_hcu u_a (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IMEM_BUSY(IMEM_BUSY),
    .DMEM_BUSY(DMEM_BUSY), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED), .ID_RD(ID_RD),
    .ID_RD_WE(ID_RD_WE), .ID_IS_LOAD(ID_IS_LOAD), .ID_IS_MEM(ID_IS_MEM),
    .EX_REDIRECT(EX_REDIRECT), .PC_WRITE(a_pcw), .STAGE_EN(a_en),
    .STAGE_BUBBLE(a_bub), .STAGE_VALID(a_sv), .FWD_A(a_fa), .FWD_B(a_fb),
    .CNT_STALL(a_cs), .CNT_FLUSH(a_cf), .CNT_RETIRE(a_cr)
  );

  core_pipe_hcu #(.FWD_EN(0), .CNT_W(4)) u_b (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IMEM_BUSY(IMEM_BUSY),
    .DMEM_BUSY(DMEM_BUSY), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED), .ID_RD(ID_RD),
    .ID_RD_WE(ID_RD_WE), .ID_IS_LOAD(ID_IS_LOAD), .ID_IS_MEM(ID_IS_MEM),
    .EX_REDIRECT(EX_REDIRECT), .PC_WRITE(b_pcw), .STAGE_EN(b_en),
    .STAGE_BUBBLE(b_bub), .STAGE_VALID(b_sv), .FWD_A(b_fa), .FWD_B(b_fb),
    .CNT_STALL(b_cs), .CNT_FLUSH(b_cf), .CNT_RETIRE(b_cr)
  );

  // Reference model: one instruction record per stage (index 1=ID .. 4=WB).
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic       mem;
    logic [4:0] rd;
  } rec_t;

  rec_t pipe [2][5];
  int   cstall [2];
  int   cflush [2];
  int   cret   [2];
  int   nerr = 0;
  int   nchk = 0;

  function automatic bit fwd_on(int k);
    return (k == 0);
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit match(int k, int s, logic [4:0] rs, logic used);
    return pipe[k][1].v && pipe[k][s].v && pipe[k][s].we &&
           (pipe[k][s].rd == rs) && (rs != 5'd0) && used;
  endfunction

  function automatic bit raw_of(int k);
    bit any = 1'b0;
    if (fwd_on(k)) begin
      return pipe[k][2].ld && (match(k, 2, ID_RS1, ID_RS1_USED) || match(k, 2, ID_RS2, ID_RS2_USED));
    end
    for (int s = 2; s <= 4; s++) begin
      if (match(k, s, ID_RS1, ID_RS1_USED) || match(k, s, ID_RS2, ID_RS2_USED)) any = 1'b1;
    end
    return any;
  endfunction

  // 0 reset, 1 dmem stall, 2 redirect, 3 raw stall, 4 fetch bubble, 5 run
  function automatic int mode_of(int k);
    if (RST) return 0;
    if (DMEM_BUSY && pipe[k][3].v && pipe[k][3].mem) return 1;
    if (EX_REDIRECT && pipe[k][2].v) return 2;
    if (raw_of(k)) return 3;
    if (IMEM_BUSY || !IF_VALID) return 4;
    return 5;
  endfunction

  function automatic int fwd_of(int k, logic [4:0] rs, logic used);
    if (RST || !fwd_on(k) || raw_of(k)) return 0;
    for (int s = 2; s <= 4; s++) begin
      if (match(k, s, rs, used)) return s;
    end
    return 0;
  endfunction

  function automatic int sat(int v, int mx);
    return (v >= mx) ? v : v + 1;
  endfunction

  task automatic model_update(int k);
    int   m = mode_of(k);
    bit   ret = pipe[k][4].v;
    rec_t idr;
    idr.v = pipe[k][1].v; idr.we = ID_RD_WE; idr.ld = ID_IS_LOAD;
    idr.mem = ID_IS_MEM; idr.rd = ID_RD;
    if (m == 0) begin
      for (int s = 0; s < 5; s++) pipe[k][s] = '0;
      cstall[k] = 0; cflush[k] = 0; cret[k] = 0;
    end else begin
      if (m == 1) begin
        pipe[k][4] = '0;
      end else begin
        pipe[k][4] = pipe[k][3];
        pipe[k][3] = pipe[k][2];
        pipe[k][2] = (m >= 4) ? idr : '0;
        if (m != 3) pipe[k][1].v = (m == 5) ? IF_VALID : 1'b0;
      end
      if (m == 1 || m == 3 || m == 4) cstall[k] = sat(cstall[k], cmax(k));
      if (m == 2) cflush[k] = sat(cflush[k], cmax(k));
      if (ret) cret[k] = sat(cret[k], cmax(k));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic pcw, input logic [3:0] en,
                           input logic [3:0] bub, input logic [3:0] sv,
                           input logic [2:0] fa, input logic [2:0] fb,
                           input logic [15:0] cs, input logic [15:0] cf,
                           input logic [15:0] cr);
    string p = (k == 0) ? "a_" : "b_";
    int    m = mode_of(k);
    logic  e_pcw;
    logic [3:0] e_en, e_bub;
    case (m)
      0:       begin e_pcw = 1'b0; e_en = 4'b0000; e_bub = 4'b1111; end
      1:       begin e_pcw = 1'b0; e_en = 4'b1000; e_bub = 4'b1000; end
      2:       begin e_pcw = 1'b1; e_en = 4'b1111; e_bub = 4'b0011; end
      3:       begin e_pcw = 1'b0; e_en = 4'b1110; e_bub = 4'b0010; end
      4:       begin e_pcw = 1'b0; e_en = 4'b1111; e_bub = 4'b0001; end
      default: begin e_pcw = 1'b1; e_en = 4'b1111; e_bub = 4'b0000; end
    endcase
    chk({p, "pc_write"}, 32'(pcw), 32'(e_pcw));
    chk({p, "stage_en"}, 32'(en), 32'(e_en));
    chk({p, "stage_bubble"}, 32'(bub), 32'(e_bub));
    chk({p, "stage_valid"}, 32'(sv), {28'd0, pipe[k][4].v, pipe[k][3].v, pipe[k][2].v, pipe[k][1].v});
    chk({p, "fwd_a"}, 32'(fa), fwd_of(k, ID_RS1, ID_RS1_USED));
    chk({p, "fwd_b"}, 32'(fb), fwd_of(k, ID_RS2, ID_RS2_USED));
    chk({p, "cnt_stall"}, 32'(cs), cstall[k]);
    chk({p, "cnt_flush"}, 32'(cf), cflush[k]);
    chk({p, "cnt_retire"}, 32'(cr), cret[k]);
  endtask

  task automatic eval();
    @(negedge CLK);
    check_dut(0, a_pcw, a_en, a_bub, a_sv, a_fa, a_fb, a_cs, a_cf, a_cr);
    check_dut(1, b_pcw, b_en, b_bub, b_sv, b_fa, b_fb, {12'd0, b_cs}, {12'd0, b_cf}, {12'd0, b_cr});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic ld, input logic mem);
    ID_RD = rd; ID_RD_WE = we; ID_RS1 = rs1; ID_RS1_USED = u1;
    ID_RS2 = rs2; ID_RS2_USED = u2; ID_IS_LOAD = ld; ID_IS_MEM = mem;
  endtask

  int s0, f0;

  initial begin
    RST = 1'b1; IF_VALID = 1'b1; IMEM_BUSY = 1'b0; DMEM_BUSY = 1'b0; EX_REDIRECT = 1'b0;
    set_id(5'd10, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    // second reset cycle
    eval();
    chk("rst_pc_write", 32'(a_pcw), 32'd0);
    chk("rst_bubble", 32'(a_bub), 32'hF);
    chk("rst_valid", 32'(a_sv), 32'd0);
    tick();
    RST = 1'b0;

    // fill with independent ALU ops
    for (int i = 1; i <= 5; i++) begin
      set_id(5'(10 + i), 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      eval();
      chk("fill_pc_write", 32'(a_pcw), 32'd1);
      tick();
      chk("fill_valid", 32'(a_sv), (i >= 4) ? 32'hF : ((32'd1 << i) - 32'd1));
      chk("fill_retire", 32'(a_cr), (i == 5) ? 32'd1 : 32'd0);
    end

    // back-to-back forward from EX
    set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval(); tick();
    set_id(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval();
    chk("fwd_ex", 32'(a_fa), 32'd2);
    chk("fwd_ex_nostall", 32'(a_pcw), 32'd1);
    tick();
    // one unrelated instruction in between: forward from MEM
    set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval(); tick();
    set_id(5'd11, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); eval(); tick();
    set_id(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval();
    chk("fwd_mem", 32'(a_fa), 32'd3);
    chk("fwd_mem_nostall", 32'(a_pcw), 32'd1);
    tick();

    // load-use
    set_id(5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1); eval(); tick();
    set_id(5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval();
    chk("lu_pc_write", 32'(a_pcw), 32'd0);
    chk("lu_bubble", 32'(a_bub), 32'b0010);
    chk("lu_en", 32'(a_en), 32'b1110);
    chk("lu_fwd_forced0", 32'(a_fa), 32'd0);
    tick();
    chk("lu_cnt_stall", 32'(a_cs), 32'd1);
    eval();
    chk("lu_resume", 32'(a_pcw), 32'd1);
    chk("lu_fwd_mem", 32'(a_fa), 32'd3);
    tick();

    // store held in MEM by DMEM_BUSY; redirect raised mid-stall
    set_id(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1); eval(); tick();
    set_id(5'd12, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); eval(); tick();
    set_id(5'd13, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    s0 = a_cs; f0 = a_cf;
    DMEM_BUSY = 1'b1;
    for (int j = 0; j < 3; j++) begin
      EX_REDIRECT = (j > 0);
      eval();
      chk("ds_pc_write", 32'(a_pcw), 32'd0);
      chk("ds_en", 32'(a_en), 32'b1000);
      chk("ds_bubble", 32'(a_bub), 32'b1000);
      tick();
      chk("ds_valid", 32'(a_sv), 32'b0111);
      chk("ds_no_flush", 32'(a_cf), 32'(f0));
    end
    chk("ds_cnt_stall", 32'(a_cs), 32'(s0 + 3));
    DMEM_BUSY = 1'b0;
    eval();
    chk("ds_redir_pc_write", 32'(a_pcw), 32'd1);
    chk("ds_redir_bubble", 32'(a_bub), 32'b0011);
    tick();
    chk("ds_redir_flush", 32'(a_cf), 32'(f0 + 1));
    chk("ds_redir_valid", 32'(a_sv), 32'b1100);
    EX_REDIRECT = 1'b0;

    // redirect in the same cycle as a load-use match
    set_id(5'd14, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); eval(); tick();
    set_id(5'd9, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1); eval(); tick();
    set_id(5'd15, 1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    EX_REDIRECT = 1'b1;
    s0 = a_cs; f0 = a_cf;
    eval();
    chk("rr_pc_write", 32'(a_pcw), 32'd1);
    chk("rr_bubble", 32'(a_bub), 32'b0011);
    chk("rr_en", 32'(a_en), 32'b1111);
    tick();
    chk("rr_flush", 32'(a_cf), 32'(f0 + 1));
    chk("rr_stall_same", 32'(a_cs), 32'(s0));
    EX_REDIRECT = 1'b0;

    // no-forwarding instance: reset, refill, add/sub RAW
    RST = 1'b1; eval(); tick(); RST = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_id(5'(16 + i), 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); eval(); tick();
    end
    set_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); eval(); tick();
    set_id(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      eval();
      chk("nf_pc_write", 32'(b_pcw), 32'd0);
      chk("nf_fwd_a", 32'(b_fa), 32'd0);
      tick();
    end
    eval();
    chk("nf_resume", 32'(b_pcw), 32'd1);
    chk("nf_fwd_a_after", 32'(b_fa), 32'd0);
    tick();
    chk("nf_cnt_stall", 32'(b_cs), 32'd3);

    // 20 fetch-stall cycles saturate the 4-bit counter
    IMEM_BUSY = 1'b1;
    for (int j = 0; j < 20; j++) begin
      eval(); tick();
    end
    chk("sat_cnt_stall", 32'(b_cs), 32'd15);
    IMEM_BUSY = 1'b0;

    // randomized traffic with a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      RST         = ($urandom_range(0, 63) == 0);
      IF_VALID    = ($urandom_range(0, 7) != 0);
      IMEM_BUSY   = ($urandom_range(0, 7) == 0);
      DMEM_BUSY   = ($urandom_range(0, 3) == 0);
      EX_REDIRECT = ($urandom_range(0, 7) == 0);
      ID_IS_LOAD  = ($urandom_range(0, 2) == 0);
      set_id(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ID_IS_LOAD, ID_IS_LOAD | 1'($urandom_range(0, 1)));
      eval(); tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/core_pipe_hcu.md
Name: core_pipe_hcu

Overview:
- Parametrised hazard-control and pipeline-sequencing unit for the RV32I in-order pipeline; generalises the fixed 5-stage HCU to NSTAGES stages.
- Tracks per-stage valid, destination register, write-enable and memory-op flags internally.
- From that state it generates PC/stage enables, bubble insertion, operand-forwarding selects and saturating performance counters.
- Sits beside the pipeline registers in core control; the datapath consumes its enables and selects.

Parameters:
- NSTAGES, 5, pipeline depth (>=4). Stage 0=IF, 1=ID, 2=EX, NSTAGES-2=MEM, NSTAGES-1=WB.
- AW, 5, register address width.
- FWD_EN, 1, 1: forwarding with load-use stall only; 0: no forwarding, stall on any RAW.
- CNT_W, 16, performance counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IF_VALID  in  1  fetched instruction presented to ID boundary this cycle.
- IMEM_BUSY  in  1  fetch outstanding.
- DMEM_BUSY  in  1  data access of the MEM-stage instruction not complete.
- ID_RS1, ID_RS2  in  AW  source registers of the instruction in ID.
- ID_RS1_USED, ID_RS2_USED  in  1  source actually read.
- ID_RD  in  AW  destination of the ID instruction.
- ID_RD_WE  in  1  ID instruction writes rd.
- ID_IS_LOAD, ID_IS_MEM  in  1  ID instruction is a load / any load or store.
- EX_REDIRECT  in  1  EX instruction is a taken branch, JAL or JALR.
- PC_WRITE  out  1  PC register update enable.
- STAGE_EN  out  NSTAGES-1  bit i: pipeline register into stage i+1 loads.
- STAGE_BUBBLE  out  NSTAGES-1  bit i: pipeline register into stage i+1 loads a NOP (valid=0).
- STAGE_VALID  out  NSTAGES-1  bit i: stage i+1 holds a valid instruction.
- FWD_A, FWD_B  out  $clog2(NSTAGES)  operand source: 0 = regfile; s in 2..NSTAGES-1 = result of stage s.
- CNT_STALL, CNT_FLUSH, CNT_RETIRE  out  CNT_W  performance counters.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - All internal valid/rd/we/mem flags, STAGE_VALID and all counters go to 0.
  - Combinational outputs while RST=1: PC_WRITE=0, STAGE_EN=0, STAGE_BUBBLE=all ones, FWD_A=FWD_B=0.
  - Reset mid-stall or mid-redirect discards all in-flight state.
- Match(s, rs): stage s valid, we(s)=1, rd(s)=rs, rs!=0, the corresponding _USED=1, and ID valid.
- Conditions, evaluated every cycle, in priority order:
  1. DSTALL = DMEM_BUSY & valid(MEM) & mem(MEM).
     - STAGE_EN bits 0..NSTAGES-3 = 0 and PC_WRITE=0, so IF..MEM hold.
     - WB boundary: EN=1, BUBBLE=1.
     - EX_REDIRECT is ignored and must stay asserted by the datapath.
  2. REDIR = EX_REDIRECT & valid(EX).
     - PC_WRITE=1; all stages advance.
     - Boundaries into ID and EX load bubbles; CNT_FLUSH+1.
  3. RAW stall:
     - FWD_EN=1: any Match(2, rs) with load(2)=1.
     - FWD_EN=0: any Match(s, rs) for s in 2..NSTAGES-1.
     - Effect: PC_WRITE=0, ID boundary EN=0 (ID holds); EX boundary loads a bubble; later stages advance.
  4. Fetch bubble: IMEM_BUSY | !IF_VALID.
     - PC_WRITE=0; ID boundary loads a bubble; the rest advance.
  5. Otherwise everything advances, PC_WRITE=1.
- Tracked flags shift with STAGE_EN and clear on bubble. Held stages retain their flags.
- FWD_A/FWD_B:
  - Value is the lowest s in 2..NSTAGES-1 with Match(s, rs); 0 if none.
  - Forced to 0 when FWD_EN=0 or when condition 3 holds.
  - Valid every cycle, combinational from state and ID inputs.
- Counters, each saturating at 2^CNT_W-1 with no wrap:
  - CNT_STALL increments every cycle PC_WRITE=0 while RST=0.
  - CNT_RETIRE increments every cycle valid(WB)=1.
- Simultaneous events: a higher-priority condition fully overrides lower ones that cycle. The lower condition is re-evaluated on the next cycle.
- x0 is never a hazard source.

Test Plan:
- Reset:
  - Stimulus: RST high 2 cycles, then IF_VALID=1 with independent ALU ops.
  - Required: STAGE_VALID=0000 during reset; then fills 0001, 0011, 0111, 1111 (one bit per cycle); CNT_RETIRE=1 on the 5th cycle after release; PC_WRITE=1 throughout.
- Forwarding (FWD_EN=1):
  - Stimulus: add x5 then sub reading x5 as rs1, back-to-back.
  - Required: FWD_A=2 while sub is in ID; with one unrelated instruction between them, FWD_A=3; no stalls.
- Load-use:
  - Stimulus: lw x7 then add reading x7.
  - Required: exactly 1 cycle PC_WRITE=0 with an EX bubble, then FWD_A=3; CNT_STALL=1.
- DMEM busy:
  - Stimulus: sw in MEM with DMEM_BUSY high 3 cycles.
  - Required: IF..MEM hold 3 cycles, WB gets 3 bubbles, CNT_STALL=3.
  - Also: EX_REDIRECT asserted during the stall is honoured only on the cycle after DMEM_BUSY falls.
- Redirect vs RAW:
  - Stimulus: EX_REDIRECT=1 in the same cycle as a load-use match.
  - Required: PC_WRITE=1, ID and EX bubbles, CNT_FLUSH=1, CNT_STALL unchanged.
- FWD_EN=0 and saturation:
  - Stimulus: add x5 then sub reading x5, with FWD_EN=0.
  - Required: 3 stall cycles, FWD_A=0 throughout.
  - With CNT_W=4: 20 stall cycles leave CNT_STALL=15.
